// File: rtl/wavegen_pkg.sv
// Shared constants, sample type and saturation helper for the square-wave generator.
package wavegen_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int unsigned CAL_SHIFT = 11;
  localparam sample_t     AMPL_MAX  = 16'sd16383;

  // Collapse a 17-bit sum to 16 bits, saturating when the top two bits disagree.
  function automatic sample_t sat16(input logic signed [16:0] x);
    if (x[16] != x[15]) begin
      return x[16] ? 16'sh8000 : 16'sh7fff;
    end
    return x[15:0];
  endfunction

endpackage

// File: rtl/sqw_gen_mc_if.sv
// Control and DAC output bundle of sqw_gen_mc; master drives settings and strobe, slave is the DUT.
interface sqw_gen_mc_if #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DAC_W = 12,
  parameter int unsigned ACC_W = 32
) ();

  logic                            clk_sampling;
  logic [NCH-1:0]                  enable;
  logic [NCH-1:0][ACC_W-1:0]       freq_word;
  logic [NCH-1:0][15:0]            duty;
  logic [NCH-1:0][15:0]            ampl;
  logic [NCH-1:0][15:0]            dc_ofs;
  logic [NCH-1:0][15:0]            cal_slope;
  logic [NCH-1:0][11:0]            cal_icpt;
  logic [NCH-1:0][DAC_W-1:0]       dac_code;
  logic                            dac_valid;

  modport master (
    output clk_sampling, enable, freq_word, duty, ampl, dc_ofs, cal_slope, cal_icpt,
    input  dac_code, dac_valid
  );

  modport slave (
    input  clk_sampling, enable, freq_word, duty, ampl, dc_ofs, cal_slope, cal_icpt,
    output dac_code, dac_valid
  );

endinterface

// File: rtl/sqw_cal_stage.sv
// Stages 2-3 of one channel: gain, intercept, midscale offset and clamp to the DAC range.
// With SQW_GEN_CAL_EN undefined stage 2 is a plain register and the intercept is ignored.
module sqw_cal_stage
  import wavegen_pkg::*;
#(
  parameter int unsigned DAC_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld2_i,
  input  logic               ld3_i,
  input  sample_t            s1_i,
  input  logic signed [15:0] cal_slope_i,
  input  logic signed [11:0] cal_icpt_i,
  output logic [DAC_W-1:0]   dac_code_o
);

  localparam logic [DAC_W-1:0] MidCode  = DAC_W'(1) << (DAC_W - 1);
  localparam logic signed [33:0] MidS   = 34'(MidCode);
  localparam logic signed [33:0] CodeMaxS = 34'((64'd1 << DAC_W) - 64'd1);

  logic signed [31:0] s1_x, s2_new, s2_d, s2_q;
  logic signed [33:0] s3;
  logic [DAC_W-1:0]   clamped, code_d, code_q;

`ifdef SQW_GEN_CAL_EN
  logic signed [31:0] slope_x, prod;

  always_comb begin
    s1_x    = {{16{s1_i[15]}}, s1_i};
    slope_x = {{16{cal_slope_i[15]}}, cal_slope_i};
    prod    = s1_x * slope_x;
    s2_new  = prod >>> CAL_SHIFT;
    s3      = {{2{s2_q[31]}}, s2_q} + {{22{cal_icpt_i[11]}}, cal_icpt_i} + MidS;
  end
`else
  logic unused_cal;
  assign unused_cal = ^{cal_slope_i, cal_icpt_i};

  always_comb begin
    s1_x   = {{16{s1_i[15]}}, s1_i};
    s2_new = s1_x;
    s3     = {{2{s2_q[31]}}, s2_q} + MidS;
  end
`endif

  always_comb begin
    // Saturate rather than wrap: out-of-range results pin to the rails.
    if (s3 < 34'sd0) begin
      clamped = '0;
    end else if (s3 > CodeMaxS) begin
      clamped = '1;
    end else begin
      clamped = s3[DAC_W-1:0];
    end
    s2_d   = ld2_i ? s2_new : s2_q;
    code_d = ld3_i ? clamped : code_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_q   <= '0;
      code_q <= MidCode;
    end else begin
      s2_q   <= s2_d;
      code_q <= code_d;
    end
  end

  assign dac_code_o = code_q;

endmodule

// File: rtl/sqw_gen_mc.sv
// Multi-channel square-wave generator: phase accumulators, level select, 3-stage DAC pipeline.
// Define SQW_GEN_CAL_EN to enable per-channel slope/intercept calibration.
module sqw_gen_mc
  import wavegen_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DAC_W = 12,
  parameter int unsigned ACC_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  sqw_gen_mc_if.slave bus
);

  logic [ACC_W-1:0]   phase_d [NCH];
  logic [ACC_W-1:0]   phase_q [NCH];
  sample_t            amp     [NCH];
  sample_t            level   [NCH];
  logic signed [16:0] sum     [NCH];
  sample_t            s1_d    [NCH];
  sample_t            s1_q    [NCH];

  logic strobe;
  logic init_d, init_q;
  logic v1_d, v1_q, v2_d, v2_q, valid_d, valid_q;
  logic [NCH-1:0][DAC_W-1:0] code;

  always_comb begin
    // init_q masks the strobe on the first edge after reset release.
    strobe  = bus.clk_sampling & init_q;
    init_d  = 1'b1;
    v1_d    = strobe;
    v2_d    = v1_q;
    valid_d = v2_q;
    for (int c = 0; c < NCH; c++) begin
      phase_d[c] = bus.enable[c] ? phase_q[c] + bus.freq_word[c] : '0;

      if ($signed(bus.ampl[c]) < 16'sd0) begin
        amp[c] = '0;
      end else if ($signed(bus.ampl[c]) > AMPL_MAX) begin
        amp[c] = AMPL_MAX;
      end else begin
        amp[c] = $signed(bus.ampl[c]);
      end

      if (!bus.enable[c]) begin
        level[c] = '0;
      end else if (phase_q[c][ACC_W-1 -: 16] < bus.duty[c]) begin
        level[c] = amp[c];
      end else begin
        level[c] = -amp[c];
      end

      sum[c] = {level[c][15], level[c]} + {bus.dc_ofs[c][15], bus.dc_ofs[c]};

      // A disabled channel feeds zero so it settles on its calibrated zero code.
      if (!strobe) begin
        s1_d[c] = s1_q[c];
      end else if (!bus.enable[c]) begin
        s1_d[c] = '0;
      end else begin
        s1_d[c] = sat16(sum[c]) >>> (15 - DAC_W);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      valid_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        phase_q[c] <= '0;
        s1_q[c]    <= '0;
      end
    end else begin
      init_q  <= init_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      valid_q <= valid_d;
      for (int c = 0; c < NCH; c++) begin
        phase_q[c] <= phase_d[c];
        s1_q[c]    <= s1_d[c];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    sqw_cal_stage #(
      .DAC_W(DAC_W)
    ) u_cal (
      .clk        (clk),
      .rst_n      (rst_n),
      .ld2_i      (v1_q),
      .ld3_i      (v2_q),
      .s1_i       (s1_q[g]),
      .cal_slope_i(bus.cal_slope[g]),
      .cal_icpt_i (bus.cal_icpt[g]),
      .dac_code_o (code[g])
    );
  end

  assign bus.dac_code  = code;
  assign bus.dac_valid = valid_q;

endmodule

// File: tb/tb_sqw_gen_mc.sv
// Directed bench for sqw_gen_mc: a spec model pushes expected codes per strobe, a monitor pops them.
module tb_sqw_gen_mc;

  localparam int NCH   = 2;
  localparam int DAC_W = 12;
  localparam int ACC_W = 32;
  localparam int MID   = 2048;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  sqw_gen_mc_if #(.NCH(NCH), .DAC_W(DAC_W), .ACC_W(ACC_W)) bus ();

  sqw_gen_mc #(.NCH(NCH), .DAC_W(DAC_W), .ACC_W(ACC_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]               cyc;
    logic [NCH-1:0][DAC_W-1:0] code;
  } exp_t;

  exp_t                      q[$];
  int                        n_vec = 0;
  int                        n_err = 0;
  int                        cyc   = 0;
  int                        n_high = 0;
  int                        n_valid_seen;
  logic                      count_en = 1'b0;
  logic [NCH-1:0][DAC_W-1:0] last_code;
  logic [ACC_W-1:0]          ph_m [NCH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference phase accumulators
  always @(posedge clk or negedge rst_n) begin
    for (int c = 0; c < NCH; c++) begin
      if (!rst_n) ph_m[c] <= '0;
      else        ph_m[c] <= bus.enable[c] ? ph_m[c] + bus.freq_word[c] : '0;
    end
  end

  function automatic int model_code(input int c);
    int amp, lvl, s;
    if (!bus.enable[c]) begin
      s = 0;
    end else begin
      amp = int'($signed(bus.ampl[c]));
      if (amp < 0) amp = 0;
      if (amp > 16383) amp = 16383;
      lvl = (ph_m[c][ACC_W-1 -: 16] < bus.duty[c]) ? amp : -amp;
      s = lvl + int'($signed(bus.dc_ofs[c]));
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      s = s >>> (15 - DAC_W);
    end
`ifdef SQW_GEN_CAL_EN
    s = (s * int'($signed(bus.cal_slope[c]))) >>> 11;
    s = s + int'($signed(bus.cal_icpt[c])) + MID;
`else
    s = s + MID;
`endif
    if (s < 0) s = 0;
    if (s > (1 << DAC_W) - 1) s = (1 << DAC_W) - 1;
    return s;
  endfunction

  // Called at a negedge after inputs are set: raise the strobe and record what it must produce.
  task automatic strobe_push();
    exp_t e;
    bus.clk_sampling = 1'b1;
    e.cyc = cyc;
    for (int c = 0; c < NCH; c++) e.code[c] = DAC_W'(model_code(c));
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    chk("drain_queue_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dac_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("valid_latency", cyc, e.cyc + 3);
          for (int c = 0; c < NCH; c++) begin
            chk($sformatf("code_ch%0d", c), bus.dac_code[c], e.code[c]);
          end
          if (count_en && bus.dac_code[0] == 12'd3048) n_high++;
          last_code = e.code;
        end
      end else begin
        chk("code_hold", bus.dac_code, last_code);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  initial begin
    bus.clk_sampling = 1'b0;
    bus.enable       = '0;
    bus.freq_word    = '0;
    bus.duty         = '0;
    bus.ampl         = '0;
    bus.dc_ofs       = '0;
    bus.cal_icpt     = '0;
    for (int c = 0; c < NCH; c++) bus.cal_slope[c] = 16'd2048;
    last_code = {NCH{12'd2048}};
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < NCH; c++) chk($sformatf("reset_code_ch%0d", c), bus.dac_code[c], MID);
    chk("reset_valid", bus.dac_valid, 0);

    // Strobe in the release cycle must be ignored.
    rst_n = 1'b1;
    bus.clk_sampling = 1'b1;
    @(negedge clk);
    bus.clk_sampling = 1'b0;
    repeat (5) @(negedge clk);

    // Nominal high/low levels
    bus.enable  = 2'b11;
    bus.ampl[0] = 16'd8000;  bus.duty[0] = 16'h8000;
    bus.ampl[1] = 16'd8000;  bus.duty[1] = 16'h0000;
    strobe_push();
    @(negedge clk);
    bus.clk_sampling = 1'b0;
    drain();
    chk("nominal_high", bus.dac_code[0], 3048);
    chk("nominal_low", bus.dac_code[1], 1048);

    // Saturation and clamping at both rails
    bus.ampl[0] = 16'd16383; bus.dc_ofs[0] = 16'd16383;
    bus.ampl[1] = 16'd16383; bus.dc_ofs[1] = 16'(-20000);
    strobe_push();
    @(negedge clk);
    bus.clk_sampling = 1'b0;
    drain();
    chk("clamp_top", bus.dac_code[0], 4095);
    chk("clamp_bottom", bus.dac_code[1], 0);

    // Offsets and non-unity calibration inside the range
    bus.ampl[0] = 16'd1000;  bus.dc_ofs[0] = 16'd300;  bus.duty[0] = 16'h0001;
    bus.ampl[1] = 16'd12000; bus.dc_ofs[1] = 16'd100;  bus.cal_slope[1] = 16'd1024;
    bus.cal_icpt[1] = 12'(-50);
    strobe_push();
    @(negedge clk);
    bus.clk_sampling = 1'b0;
    drain();

    // Back-to-back strobes with levels changing every cycle
    bus.dc_ofs = '0; bus.cal_slope[1] = 16'd2048; bus.cal_icpt[1] = 12'd0;
    for (int i = 0; i < 3; i++) begin
      bus.duty[0] = (i % 2 == 0) ? 16'h8000 : 16'h0000;
      bus.ampl[1] = 16'(1000 + 3000 * i);
      strobe_push();
      @(negedge clk);
    end
    bus.ampl[0] = 16'd50; bus.ampl[1] = 16'd50;
    bus.clk_sampling = 1'b0;
    drain();

    // Disable channel 1 mid-run: calibrated zero code
    bus.ampl[0] = 16'd8000; bus.duty[0] = 16'h8000;
    bus.ampl[1] = 16'd9000; bus.duty[1] = 16'h8000; bus.cal_icpt[1] = 12'd24;
    strobe_push();
    @(negedge clk);
    bus.enable[1] = 1'b0;
    strobe_push();
    @(negedge clk);
    bus.clk_sampling = 1'b0;
    drain();
`ifdef SQW_GEN_CAL_EN
    chk("disabled_zero_code", bus.dac_code[1], 2072);
`else
    chk("disabled_zero_code", bus.dac_code[1], 2048);
`endif
    chk("ch0_unaffected", bus.dac_code[0], 3048);

    // Phase accumulator: 1000-clk period, high for 500 samples
    bus.enable = '0; bus.cal_icpt[1] = 12'd0;
    @(negedge clk);
    n_high = 0;
    count_en = 1'b1;
    bus.enable[0] = 1'b1;
    bus.freq_word[0] = 32'd4294968;
    for (int i = 0; i < 1000; i++) begin
      strobe_push();
      @(negedge clk);
    end
    bus.clk_sampling = 1'b0;
    drain();
    count_en = 1'b0;
    chk("high_samples_per_period", n_high, 500);

    // Phase-continuous frequency change on both channels
    bus.enable = 2'b11;
    bus.freq_word[1] = 32'h0123_4567;
    for (int i = 0; i < 24; i++) begin
      if (i == 8) bus.freq_word[0] = 32'h1000_0000;
      if (i == 16) bus.freq_word[1] = 32'h2AAA_AAAB;
      strobe_push();
      @(negedge clk);
    end
    bus.clk_sampling = 1'b0;
    drain();

    // Reset one cycle after a strobe: in-flight sample discarded
    bus.freq_word = '0;
    bus.enable = '0;
    @(negedge clk);
    bus.enable = 2'b11;
    bus.duty[0] = 16'h8000; bus.duty[1] = 16'h0000;
    bus.ampl[0] = 16'd8000; bus.ampl[1] = 16'd8000;
    strobe_push();
    @(negedge clk);
    bus.clk_sampling = 1'b0;
    drain();
    strobe_push();
    @(negedge clk);
    bus.clk_sampling = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < NCH; c++) chk($sformatf("async_reset_code_ch%0d", c), bus.dac_code[c], MID);
    chk("async_reset_valid", bus.dac_valid, 0);
    q.delete();
    last_code = {NCH{12'd2048}};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_valid_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.dac_valid) n_valid_seen++;
    end
    chk("no_valid_after_reset", n_valid_seen, 0);

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sqw_gen_mc.md
SQW_GEN_MC -- requirements
Module: sqw_gen_mc

Interface
REQ-001 Parameter NCH, default 2: number of independent square-wave channels (1..8).
REQ-002 Parameter DAC_W, default 12: DAC code width in bits (10..14).
REQ-003 Parameter ACC_W, default 32: phase accumulator width in bits (24..32).
REQ-004 Port clk  input  1: single system clock; all logic on rising edge.
REQ-005 Port rst_n  input  1: reset; asynchronous assert, active-low.
REQ-006 Port clk_sampling  input  1: one-cycle sample strobe (50 kHz nominal).
REQ-007 Port enable  input  NCH: per-channel run enable.
REQ-008 Port freq_word  input  NCH x ACC_W: per-channel unsigned phase increment per clk.
REQ-009 Port duty  input  NCH x 16: per-channel high fraction, unsigned; 0x0000 = 0 %, 0xFFFF = about 100 %.
REQ-010 Port ampl  input  NCH x 16 signed: per-channel amplitude, legal range 0..16383.
REQ-011 Port dc_ofs  input  NCH x 16 signed: per-channel DC offset.
REQ-012 Port cal_slope  input  NCH x 16 signed: per-channel gain; Q5.11 format, 2048 = 1.0.
REQ-013 Port cal_icpt  input  NCH x 12 signed: per-channel intercept, in DAC codes.
REQ-014 Port dac_code  output  NCH x DAC_W: per-channel unsigned DAC word.
REQ-015 Port dac_valid  output  1: one-cycle pulse, high when dac_code has updated.

Function
REQ-016 Each enabled channel SHALL add freq_word to its phase accumulator every clk, with modulo-2^ACC_W wrap.
REQ-017 A disabled channel SHALL hold its phase at 0, and its level SHALL be 0.
REQ-018 An enabled channel's level SHALL be +ampl when phase[ACC_W-1 -: 16] < duty, and -ampl otherwise.
REQ-019 duty = 0 SHALL give a constant level of -ampl.
REQ-020 Stage 1, on clk_sampling: s1 = saturate16(level + dc_ofs), then arithmetic shift right by (15-DAC_W).
REQ-021 Stage 2: s2 = (s1 * cal_slope) >>> CAL_SHIFT (11), computed at full 32-bit signed width.
REQ-022 Stage 3: s3 = s2 + cal_icpt + 2^(DAC_W-1), clamped to 0..2^DAC_W-1, then registered to dac_code.
REQ-023 Clamping SHALL be a true clamp: no wrap, no truncation to the low DAC_W bits.
REQ-024 dac_code and dac_valid SHALL update exactly 3 clk after the clk_sampling cycle, for all channels together.
REQ-025 Back-to-back clk_sampling pulses SHALL be fully pipelined: one result per strobe, none dropped.
REQ-026 Stage 1 SHALL sample ampl, dc_ofs, duty and level in the strobe cycle; later input changes SHALL not affect that sample.
REQ-027 Between strobes, dac_code SHALL hold its value.
REQ-028 Changing freq_word SHALL take effect on the next clk, with no phase reset (phase-continuous).
REQ-029 A channel dropping enable SHALL emit its calibrated zero code (midscale + cal_icpt, clamped) from the next strobe on.

Reset
REQ-030 While rst_n is low: all phases = 0, all pipeline registers = 0, dac_code = 2^(DAC_W-1) on every channel, dac_valid = 0.
REQ-031 A strobe in flight when reset asserts SHALL be discarded; no dac_valid SHALL follow reset release for it.
REQ-032 clk_sampling SHALL be ignored in the cycle rst_n deasserts.

Configuration
REQ-033 Macro SQW_GEN_CAL_EN defined: stage 2 and the cal_icpt add SHALL be implemented as in REQ-021 and REQ-022.
REQ-034 Macro SQW_GEN_CAL_EN undefined: stage 2 SHALL be a plain register (s2 = s1), cal_icpt SHALL be ignored, and latency SHALL stay 3 cycles.

Structure
REQ-035 Package wavegen_pkg SHALL hold CAL_SHIFT = 11, AMPL_MAX = 16383, and a typedef for the signed 16-bit sample.
REQ-036 Sub-module sqw_cal_stage SHALL implement stages 2-3 for one channel, instantiated NCH times via generate.

Verification
REQ-037 freq_word = 2^ACC_W/1000, duty = 0x8000, ampl = 8000: phase MSB period = 1000 clk; level high exactly 500 clk.
REQ-038 ampl = 8000, dc_ofs = 0, cal_slope = 2048, cal_icpt = 0, DAC_W = 12: high level -> dac_code 3048, low level -> 1048, dac_valid 3 clk after strobe.
REQ-039 ampl = 16383, dc_ofs = 16383: saturate -> dac_code 4095; ampl = 16383, dc_ofs = -20000 -> dac_code 0, with no wrap.
REQ-040 Strobes on 3 consecutive cycles with the level changing each cycle: 3 consecutive dac_valid pulses carrying the matching codes.
REQ-041 Drop enable on channel 1 mid-run with cal_icpt = 24: next strobe gives dac_code[1] = 2072; channel 0 unaffected.
REQ-042 Assert rst_n low one cycle after a strobe: no dac_valid afterwards; dac_code = 2048 immediately (asynchronous reset).
